// File: rtl/mac_seq.sv
// Sequencer for an accumulate-only MAC: clears it, streams N_TERMS operand pairs
// from a synchronous memory, then scales and saturates the accumulator to int8.
module mac_seq #(
  parameter int N_TERMS = 784,
  parameter int ADDR_W  = 10,
  parameter int ACC_W   = 26,
  parameter int FRAC    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [7:0]        result,
  output logic              sat,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        a_data,
  input  logic [7:0]        b_data,
  output logic [7:0]        mac_in1,
  output logic [7:0]        mac_in2,
  output logic              mac_clr,
  input  logic [ACC_W-1:0]  mac_acc
);

  // state | meaning
  // IDLE  | waiting for start; mem_addr parked at 0
  // CLR   | MAC cleared, address 0 issued
  // FEED  | addresses 1..N_TERMS-1 issued, one per cycle
  // FLUSH | no address; last operand pair enters the MAC
  // CAPT  | accumulator final; scale, saturate, register result
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
    S_FLUSH,
    S_CAPT
  } state_t;

  localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(N_TERMS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI    = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO    = ACC_W'(-128);

  state_t                   state, state_nxt;
  logic [ADDR_W-1:0]        addr_nxt;
  logic                     issue;
  logic                     rd_vld;
  logic signed [ACC_W-1:0]  scaled;
  logic [7:0]               result_nxt;
  logic                     sat_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mem_addr <= '0;
      rd_vld   <= 1'b0;
    end else begin
      state    <= state_nxt;
      mem_addr <= addr_nxt;
      rd_vld   <= issue;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = mem_addr;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        addr_nxt = '0;
        if (start) state_nxt = S_CLR;
      end
      S_CLR: begin
        issue = 1'b1;
        if (N_TERMS > 1) begin
          state_nxt = S_FEED;
          addr_nxt  = ADDR_W'(1);
        end else begin
          state_nxt = S_FLUSH;
          addr_nxt  = '0;
        end
      end
      S_FEED: begin
        issue = 1'b1;
        // Hold the last address so mem_addr never runs past the operand table.
        if (mem_addr == LAST_ADDR) begin
          state_nxt = S_FLUSH;
        end else begin
          addr_nxt = mem_addr + ADDR_W'(1);
        end
      end
      S_FLUSH: state_nxt = S_CAPT;
      S_CAPT: begin
        state_nxt = S_IDLE;
        addr_nxt  = '0;
      end
      default: begin
        state_nxt = S_IDLE;
        addr_nxt  = '0;
      end
    endcase
  end

  assign scaled = $signed(mac_acc) >>> FRAC;

  always_comb begin
    result_nxt = scaled[7:0];
    sat_nxt    = 1'b0;
    if (scaled > SAT_HI) begin
      result_nxt = 8'h7f;
      sat_nxt    = 1'b1;
    end else if (scaled < SAT_LO) begin
      result_nxt = 8'h80;
      sat_nxt    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done   <= 1'b0;
      result <= '0;
      sat    <= 1'b0;
    end else begin
      done <= (state == S_CAPT);
      if (state == S_CAPT) begin
        result <= result_nxt;
        sat    <= sat_nxt;
      end
    end
  end

  assign busy = (state != S_IDLE);

  // The MAC has no enable: operands must be zero whenever no read data is in flight.
  assign mac_in1 = rd_vld ? a_data : 8'h00;
  assign mac_in2 = rd_vld ? b_data : 8'h00;
  assign mac_clr = ~rst_n | (state == S_CLR);

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: four parameterisations, each with its own operand memory and
// MAC model, checked every cycle against a run-phase model plus literal expectations.
module tb_mac_seq;

  localparam int NI = 4;

  function automatic int nt(input int i);
    case (i)
      0:       return 6;
      1:       return 3;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int fr(input int i);
    return (i == 0) ? 0 : 7;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              start    [NI];
  logic              busy     [NI];
  logic              done     [NI];
  logic [7:0]        result   [NI];
  logic              sat      [NI];
  logic [2:0]        mem_addr [NI];
  logic signed [7:0] a_data   [NI];
  logic signed [7:0] b_data   [NI];
  logic signed [7:0] mac_in1  [NI];
  logic signed [7:0] mac_in2  [NI];
  logic              mac_clr  [NI];
  logic signed [25:0] acc     [NI];

  logic signed [7:0] mem_a [NI][8];
  logic signed [7:0] mem_b [NI][8];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mac_seq #(.N_TERMS(nt(g)), .ADDR_W(3), .ACC_W(26), .FRAC(fr(g))) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .result(result[g]), .sat(sat[g]), .mem_addr(mem_addr[g]),
      .a_data(a_data[g]), .b_data(b_data[g]), .mac_in1(mac_in1[g]),
      .mac_in2(mac_in2[g]), .mac_clr(mac_clr[g]), .mac_acc(acc[g])
    );
  end

  // Operand memories (1-cycle read) and MAC datapaths.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      a_data[i] <= mem_a[i][mem_addr[i]];
      b_data[i] <= mem_b[i][mem_addr[i]];
      if (mac_clr[i]) acc[i] <= '0;
      else            acc[i] <= acc[i] + mac_in1[i] * mac_in2[i];
    end
  end

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase k of a run (0 = idle, 1 = CLR cycle, N+3 = done cycle).
  int                phase   [NI];
  logic signed [7:0] exp_res [NI];
  logic              exp_sat [NI];
  logic signed [7:0] pend_res[NI];
  logic              pend_sat[NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      phase[i] = 0; exp_res[i] = 0; exp_sat[i] = 0; pend_res[i] = 0; pend_sat[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        phase[i] = 0; exp_res[i] = 0; exp_sat[i] = 0;
      end else if (phase[i] == 0 || phase[i] == nt(i) + 3) begin
        if (start[i]) begin
          int s;
          s = 0;
          for (int j = 0; j < nt(i); j++) s += int'(mem_a[i][j]) * int'(mem_b[i][j]);
          s = s >>> fr(i);
          if (s > 127)       begin pend_res[i] = 127;      pend_sat[i] = 1; end
          else if (s < -128) begin pend_res[i] = -128;     pend_sat[i] = 1; end
          else               begin pend_res[i] = 8'(s);    pend_sat[i] = 0; end
          phase[i] = 1;
        end else begin
          phase[i] = 0;
        end
      end else begin
        phase[i]++;
        if (phase[i] == nt(i) + 3) begin
          exp_res[i] = pend_res[i];
          exp_sat[i] = pend_sat[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        int k, n;
        k = phase[i];
        n = nt(i);
        chk($sformatf("busy[%0d]", i), int'(busy[i]), int'(k >= 1 && k <= n + 2));
        chk($sformatf("done[%0d]", i), int'(done[i]), int'(k == n + 3));
        chk($sformatf("result[%0d]", i), int'($signed(result[i])), int'(exp_res[i]));
        chk($sformatf("sat[%0d]", i), int'(sat[i]), int'(exp_sat[i]));
        chk($sformatf("mac_clr[%0d]", i), int'(mac_clr[i]), int'(!rst_n || k == 1));
        chk($sformatf("mac_in1[%0d]", i), int'(mac_in1[i]),
            (k >= 2 && k <= n + 1) ? int'(mem_a[i][k-2]) : 0);
        chk($sformatf("mac_in2[%0d]", i), int'(mac_in2[i]),
            (k >= 2 && k <= n + 1) ? int'(mem_b[i][k-2]) : 0);
        chk($sformatf("addr_max[%0d]", i), int'(int'(mem_addr[i]) <= n - 1), 1);
        if (k >= 1 && k <= n)
          chk($sformatf("mem_addr[%0d]", i), int'(mem_addr[i]), k - 1);
        else if (k == 0 || k == n + 3)
          chk($sformatf("mem_addr_idle[%0d]", i), int'(mem_addr[i]), 0);
      end
    end
  end

  task automatic load(input int i, input int a[8], input int b[8]);
    for (int j = 0; j < 8; j++) begin
      mem_a[i][j] = 8'(a[j]);
      mem_b[i][j] = 8'(b[j]);
    end
  endtask

  // Returns in the done cycle (at its falling edge); lat counts cycles from the
  // start-sampling edge, starting at 1 for the CLR cycle.
  task automatic wait_done(input int i, input int lat0, output int lat);
    lat = lat0;
    while (lat < 100) begin
      @(negedge clk);
      if (done[i]) return;
      @(posedge clk);
      lat++;
    end
    chk($sformatf("done_timeout[%0d]", i), 0, 1);
    lat = -1;
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk); #2 start[i] = 1'b1;
    @(posedge clk); #2 start[i] = 1'b0;
  endtask

  task automatic count_done(input int i, input int ncyc, output int c);
    c = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (done[i]) c++;
    end
  endtask

  int lat, c;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      load(i, '{0,0,0,0,0,0,0,0}, '{0,0,0,0,0,0,0,0});
    end
    @(posedge clk); #2 chk_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_busy[%0d]", i), int'(busy[i]), 0);
      chk($sformatf("rst_result[%0d]", i), int'(result[i]), 0);
      chk($sformatf("rst_clr[%0d]", i), int'(mac_clr[i]), 1);
      chk($sformatf("rst_addr[%0d]", i), int'(mem_addr[i]), 0);
    end
    @(posedge clk); #2 rst_n = 1'b1;

    // Mixed-sign dot product, FRAC=0.
    load(0, '{2,-2,-3,30,-8,4,0,0}, '{5,5,8,2,5,1,0,0});
    pulse_start(0);
    wait_done(0, 1, lat);
    chk("t1_latency", lat, 9);
    chk("t1_result", int'($signed(result[0])), 0);
    chk("t1_sat", int'(sat[0]), 0);

    // 64*64*3 >>> 7, then back-to-back into a negative saturating run.
    load(1, '{64,64,64,0,0,0,0,0}, '{64,64,64,0,0,0,0,0});
    pulse_start(1);
    wait_done(1, 1, lat);
    chk("t2_latency", lat, 6);
    chk("t2_result", int'($signed(result[1])), 96);
    chk("t2_sat", int'(sat[1]), 0);
    load(1, '{-126,-126,-126,0,0,0,0,0}, '{126,126,126,0,0,0,0,0});
    start[1] = 1'b1;
    @(posedge clk); #2 start[1] = 1'b0;
    wait_done(1, 1, lat);
    chk("b2b_latency", lat, 6);
    chk("t3_result", int'($signed(result[1])), -128);
    chk("t3_sat", int'(sat[1]), 1);

    // Positive saturation.
    load(2, '{127,127,0,0,0,0,0,0}, '{127,127,0,0,0,0,0,0});
    pulse_start(2);
    wait_done(2, 1, lat);
    chk("t4_latency", lat, 5);
    chk("t4_result", int'($signed(result[2])), 127);
    chk("t4_sat", int'(sat[2]), 1);

    // Single-term run.
    load(3, '{-64,0,0,0,0,0,0,0}, '{64,0,0,0,0,0,0,0});
    pulse_start(3);
    wait_done(3, 1, lat);
    chk("t5_latency", lat, 4);
    chk("t5_result", int'($signed(result[3])), -32);
    chk("t5_sat", int'(sat[3]), 0);

    // Start during FEED is ignored.
    load(0, '{1,2,3,4,5,6,0,0}, '{1,1,1,1,1,1,0,0});
    pulse_start(0);
    repeat (2) @(posedge clk);
    #2 start[0] = 1'b1;
    @(posedge clk); #2 start[0] = 1'b0;
    wait_done(0, 4, lat);
    chk("busy_start_latency", lat, 9);
    chk("busy_start_result", int'($signed(result[0])), 21);
    count_done(0, 12, c);
    chk("busy_start_extra_done", c, 0);

    // Reset mid-FEED aborts the run.
    pulse_start(0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_result", int'(result[0]), 0);
    chk("abort_sat", int'(sat[0]), 0);
    count_done(0, 12, c);
    chk("abort_no_done", c, 0);

    // Fresh run after abort: no residue in the MAC.
    pulse_start(0);
    wait_done(0, 1, lat);
    chk("rerun_latency", lat, 9);
    chk("rerun_result", int'($signed(result[0])), 21);
    chk("rerun_sat", int'(sat[0]), 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
